ysyx_24100006_clint_reader: RTL and testbench

AXI-Lite read initiator that fetches the 64-bit `mtime` value from the CLINT timer as two 32-bit reads and returns one consistent 64-bit sample to a requester (CSR unit / `rdtime` path). It sits between the core-side request port and the CLINT AXI-Lite read channel. It issues AR requests, accepts R beats, and guards against a low-word carry between the two halves by re-reading the high word.

---
 rtl/ysyx_24100006_clint_reader.sv | 176 +++++++++++++++++
 tb/tb_ysyx_24100006_clint_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_clint_reader.sv
// AXI-Lite initiator returning one consistent 64-bit CLINT mtime sample.
// Define YSYX_24100006_CLINT_RD_CHK_EN for the HI-LO-HI carry check with bounded re-reads.
module ysyx_24100006_clint_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] AR_LO  = 3'd3;
  localparam logic [2:0] R_LO   = 3'd4;
  localparam logic [2:0] AR_HI2 = 3'd5;
  localparam logic [2:0] R_HI2  = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;
  localparam logic [31:0] HI_ADDR = BASE_ADDR + 32'd4;
`ifdef YSYX_24100006_CLINT_RD_CHK_EN
  localparam logic [2:0] AR_HI1 = 3'd1;
  localparam logic [2:0] R_HI1  = 3'd2;
  localparam logic [2:0] START  = AR_HI1;
  localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);
  logic [31:0] hi1;
  logic [1:0]  retry;
  logic        mismatch;
  assign mismatch = (axi_rdata != hi1);
`else
  localparam logic [2:0] START  = AR_LO;
`endif

  logic [2:0]  state;
  logic [2:0]  next;
  logic        next_ar;
  logic        next_r;
  logic [31:0] next_addr;
  logic [31:0] lo;
  logic [31:0] hi2;
  logic        err;
  logic        r_beat;
  logic        bus_err;

  assign r_beat  = axi_rvalid & axi_rready;
  assign bus_err = (axi_rresp != 2'b00);

  // Next-state selection for the read sequencer.
  always_comb begin
    next = state;
    case (state)
      IDLE:   if (req_valid) next = START; else next = IDLE;
`ifdef YSYX_24100006_CLINT_RD_CHK_EN
      AR_HI1: if (axi_arready) next = R_HI1; else next = AR_HI1;
      R_HI1:  if (r_beat) next = AR_LO; else next = R_HI1;
`endif
      AR_LO:  if (axi_arready) next = R_LO; else next = AR_LO;
      R_LO:   if (r_beat) next = AR_HI2; else next = R_LO;
      AR_HI2: if (axi_arready) next = R_HI2; else next = AR_HI2;
      R_HI2: begin
        if (r_beat) begin
`ifdef YSYX_24100006_CLINT_RD_CHK_EN
          // A carry between the halves moved hi: re-read lo and hi while retries remain.
          if (mismatch && (retry != RETRY_LIM)) next = AR_LO; else next = DONE;
`else
          next = DONE;
`endif
        end else begin
          next = R_HI2;
        end
      end
      DONE:   if (resp_valid && resp_ready) next = IDLE; else next = DONE;
      default: next = IDLE;
    endcase
  end

  // Bus-side output values implied by the upcoming state.
  always_comb begin
    next_ar   = 1'b0;
    next_r    = 1'b0;
    next_addr = 32'h0000_0000;
    case (next)
      AR_LO: begin next_ar = 1'b1; next_addr = BASE_ADDR; end
      AR_HI2: begin next_ar = 1'b1; next_addr = HI_ADDR; end
`ifdef YSYX_24100006_CLINT_RD_CHK_EN
      AR_HI1: begin next_ar = 1'b1; next_addr = HI_ADDR; end
      R_HI1: next_r = 1'b1;
`endif
      R_LO:  next_r = 1'b1;
      R_HI2: next_r = 1'b1;
      default: next_r = 1'b0;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      axi_araddr  <= 32'h0000_0000;
    end else begin
      state       <= next;
      req_ready   <= (next == IDLE);
      axi_arvalid <= next_ar;
      axi_rready  <= next_r;
      axi_araddr  <= next_addr;
    end
  end

  // Captured halves, sticky error and the response register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo         <= 32'h0000_0000;
      hi2        <= 32'h0000_0000;
      err        <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= 64'h0000_0000_0000_0000;
      resp_err   <= 1'b0;
`ifdef YSYX_24100006_CLINT_RD_CHK_EN
      hi1        <= 32'h0000_0000;
      retry      <= 2'd0;
`endif
    end else begin
      if ((state == IDLE) && req_valid) begin
        err <= 1'b0;
`ifdef YSYX_24100006_CLINT_RD_CHK_EN
        retry <= 2'd0;
`endif
      end else if (r_beat) begin
        err <= err | bus_err;
        case (state)
`ifdef YSYX_24100006_CLINT_RD_CHK_EN
          R_HI1: hi1 <= axi_rdata;
`endif
          R_LO:  lo <= axi_rdata;
          R_HI2: begin
            hi2 <= axi_rdata;
`ifdef YSYX_24100006_CLINT_RD_CHK_EN
            if (mismatch) begin
              if (retry != RETRY_LIM) begin
                retry <= retry + 2'd1;
                hi1   <= axi_rdata;
              end else begin
                err <= 1'b1;
              end
            end
`endif
          end
          default: err <= err | bus_err;
        endcase
      end
      if (state == DONE) begin
        if (!resp_valid) begin
          resp_valid <= 1'b1;
          resp_data  <= {hi2, lo};
          resp_err   <= err;
        end else if (resp_ready) begin
          resp_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_clint_reader.sv
// Directed bench for ysyx_24100006_clint_reader with a scripted AXI-Lite slave and a
// sequence-level model of the expected sample, address order and latency.
module tb_ysyx_24100006_clint_reader;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] HIA  = 32'h0200_0004;
`ifdef YSYX_24100006_CLINT_RD_CHK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, resp_err;
  logic [63:0] resp_data;
  logic [31:0] axi_araddr, axi_rdata;
  logic axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [1:0] axi_rresp;

  always #5 clk = ~clk;

  ysyx_24100006_clint_reader dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // scripted slave contents
  logic [31:0] hv[8];
  logic [31:0] lv[8];
  int hn, ln, lo_err, arw, rw, hi_i, lo_i, ar_cnt, r_cnt;
  logic lo_stall = 1'b0;
  logic [31:0] cur_addr = 32'h0;

  function automatic int cl(input int i, input int n);
    return (i < n) ? i : n - 1;
  endfunction

  // AXI-Lite slave: reacts just after each falling edge
  initial begin
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = 32'h0; axi_rresp = 2'b00;
    ar_cnt = 0; r_cnt = 0;
    forever begin
      @(negedge clk); #1;
      if (!reset) begin
        axi_arready = 1'b0; axi_rvalid = 1'b0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (axi_arvalid && !axi_arready) begin
          if (ar_cnt >= arw) begin axi_arready = 1'b1; cur_addr = axi_araddr; ar_cnt = 0; end
          else ar_cnt++;
        end else axi_arready = 1'b0;
        if (axi_rready && !axi_rvalid && !(lo_stall && cur_addr == BASE)) begin
          if (r_cnt >= rw) begin
            axi_rvalid = 1'b1; r_cnt = 0;
            if (cur_addr == HIA) begin
              axi_rdata = hv[cl(hi_i, hn)]; axi_rresp = 2'b00; hi_i++;
            end else begin
              axi_rdata = lv[cl(lo_i, ln)];
              axi_rresp = (lo_i == lo_err) ? 2'b10 : 2'b00; lo_i++;
            end
          end else r_cnt++;
        end else begin
          axi_rvalid = 1'b0; axi_rresp = 2'b00;
        end
      end
    end
  end

  // model outputs
  logic [63:0] exp_data;
  logic        exp_err;
  int          exp_lat, exp_n;
  logic [31:0] exp_addr[16];

  task automatic model();
    logic [31:0] h1, h2, l;
    int r, hk, lk;
    bit fin;
    exp_n = 0; exp_err = 1'b0; r = 0; hk = 0; lk = 0; fin = 0; h2 = 32'h0; l = 32'h0;
    if (CHK == 1) begin
      h1 = hv[0]; hk = 1; exp_addr[exp_n++] = HIA;
      for (int k = 0; k < 8 && !fin; k++) begin
        exp_addr[exp_n++] = BASE; exp_addr[exp_n++] = HIA;
        l = lv[cl(lk, ln)]; if (lk == lo_err) exp_err = 1'b1; lk++;
        h2 = hv[cl(hk, hn)]; hk++;
        if (h2 == h1) fin = 1;
        else if (r < 3) begin r++; h1 = h2; end
        else begin exp_err = 1'b1; fin = 1; end
      end
    end else begin
      exp_addr[exp_n++] = BASE; exp_addr[exp_n++] = HIA;
      l = lv[0]; h2 = hv[0]; exp_err = (lo_err == 0);
    end
    exp_data = {h2, l};
    exp_lat = exp_n * (2 + arw + rw) + 1;
  endtask

  // per-cycle compare against the model
  bit chk_on = 0;
  int hs_count = 0;
  logic prev_arv = 1'b0, prev_ard = 1'b0;
  initial begin
    forever begin
      @(negedge clk); #2;
      if (chk_on && reset) begin
        if (prev_arv && prev_ard) hs_count++;
        if (axi_arvalid)
          chk("araddr", 64'(axi_araddr), 64'((hs_count < exp_n) ? exp_addr[hs_count] : 32'hDEAD_BEEF));
        chk("one_txn", 64'(axi_arvalid & axi_rready), 64'(1'b0));
        if (resp_valid) begin
          chk("resp_data", resp_data, exp_data);
          chk("resp_err", 64'(resp_err), 64'(exp_err));
        end
      end
      prev_arv = axi_arvalid; prev_ard = axi_arready;
    end
  end

  int lat;
  task automatic run(input int a_w, input int r_w);
    arw = a_w; rw = r_w; hi_i = 0; lo_i = 0; model();
    hs_count = 0; prev_arv = 1'b0; prev_ard = 1'b0; chk_on = 1;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'(1'b1));
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!resp_valid && lat < 400);
    chk("latency", 64'(lat), 64'(exp_lat));
    repeat (3) @(negedge clk);
    chk("resp_hold", 64'(resp_valid), 64'(1'b1));
    req_valid = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    chk("resp_drop", 64'(resp_valid), 64'(1'b0));
    chk("req_ready_back", 64'(req_ready), 64'(1'b1));
    chk("no_accept_in_done", 64'(axi_arvalid), 64'(1'b0));
    req_valid = 1'b0; resp_ready = 1'b0;
    chk("read_count", 64'(hs_count), 64'(exp_n));
    chk_on = 0;
  endtask

  task automatic set1(input logic [31:0] h, input logic [31:0] l);
    hv[0] = h; hn = 1; lv[0] = l; ln = 1; lo_err = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    arw = 0; rw = 0; hi_i = 0; lo_i = 0; set1(32'h1, 32'h10);
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'(1'b0));
    chk("rst_arvalid", 64'(axi_arvalid), 64'(1'b0));
    chk("rst_rready", 64'(axi_rready), 64'(1'b0));
    chk("rst_araddr", 64'(axi_araddr), 64'(32'h0));
    chk("rst_resp_data", resp_data, 64'h0);
    chk("rst_resp_err", 64'(resp_err), 64'(1'b0));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1'b1));

    // stable mtime, zero-wait
    set1(32'h0000_0001, 32'h0000_0010);
    run(0, 0);
    chk("t1_model", exp_data, 64'h0000_0001_0000_0010);
    chk("t1_data", resp_data, 64'h0000_0001_0000_0010);
    chk("t1_err", 64'(resp_err), 64'(1'b0));
    chk("t1_lat", 64'(lat), 64'((CHK == 1) ? 7 : 5));

    // carry between halves: one retry
    hv[0] = 32'h1; hv[1] = 32'h2; hv[2] = 32'h2; hn = 3;
    lv[0] = 32'h2; lv[1] = 32'h5; ln = 2; lo_err = -1;
    run(0, 0);
    chk("t2_data", resp_data, (CHK == 1) ? 64'h0000_0002_0000_0005 : 64'h0000_0001_0000_0002);
    chk("t2_err", 64'(resp_err), 64'(1'b0));
    chk("t2_lat", 64'(lat), 64'((CHK == 1) ? 11 : 5));

    // hi differs on every read: retry exhaustion
    for (int i = 0; i < 8; i++) hv[i] = 32'(i + 1);
    hn = 8; lv[0] = 32'h7; ln = 1; lo_err = -1;
    run(0, 0);
    chk("t3_data", resp_data, (CHK == 1) ? 64'h0000_0005_0000_0007 : 64'h0000_0001_0000_0007);
    chk("t3_err", 64'(resp_err), 64'((CHK == 1) ? 1'b1 : 1'b0));
    chk("t3_lat", 64'(lat), 64'((CHK == 1) ? 19 : 5));

    // slow slave: arready after 4 cycles, rvalid after 3
    set1(32'h0000_000A, 32'h0000_000B);
    run(4, 3);
    chk("t4_data", resp_data, 64'h0000_000A_0000_000B);
    chk("t4_lat", 64'(lat), 64'((CHK == 1) ? 28 : 19));

    // error response on the lo beat
    set1(32'h3, 32'h4); lo_err = 0;
    run(0, 0);
    chk("t5_data", resp_data, 64'h0000_0003_0000_0004);
    chk("t5_err", 64'(resp_err), 64'(1'b1));

    // reset while waiting in R_LO
    set1(32'h1, 32'h10); arw = 0; rw = 0; hi_i = 0; lo_i = 0; lo_stall = 1'b1;
    @(negedge clk); req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_rready && cur_addr == BASE) break;
    end
    chk("t6_in_r_lo", 64'(axi_rready && cur_addr == BASE), 64'(1'b1));
    reset = 1'b0;
    #1;
    chk("t6_arvalid_drop", 64'(axi_arvalid), 64'(1'b0));
    chk("t6_rready_drop", 64'(axi_rready), 64'(1'b0));
    repeat (2) @(negedge clk);
    lo_stall = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("t6_req_ready", 64'(req_ready), 64'(1'b1));
    set1(32'h0000_0001, 32'h0000_0010);
    run(0, 0);
    chk("t6_data", resp_data, 64'h0000_0001_0000_0010);
    chk("t6_err", 64'(resp_err), 64'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
